// File: rtl/score_pkg.sv
// Shared definitions for the score path: sequencer FSM states, the BCD
// ceiling of the 3-digit score counter and the default line-clear points table.
// Latency: n/a (types and constants only). Backpressure: n/a.
package score_pkg;

   // Sequencer states. SAT is terminal until reset.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2,
      SAT   = 2'd3
   } state_t;

   // Largest value the 3-digit BCD counter can hold; reaching it stops scoring.
   localparam logic [11:0] BCD_MAX = 12'h999;

   // Default points awarded for clearing 1..4 lines. The level/speed logic
   // reads the same table through score_points_lut.
   localparam int unsigned DEF_PTS_1 = 1;
   localparam int unsigned DEF_PTS_2 = 3;
   localparam int unsigned DEF_PTS_3 = 5;
   localparam int unsigned DEF_PTS_4 = 8;

   // Width of the gap counter between hits; bounds the usable HIT_GAP.
   localparam int unsigned GAP_W   = 4;
   localparam int unsigned GAP_MAX = (1 << GAP_W) - 1;

endpackage

// File: rtl/score_points_lut.sv
// Combinational decode of a line-clear count into the points it is worth.
// Latency: 0 cycles (pure combinational). Backpressure: none, always valid.
// Ports: lines [2:0] in (lines cleared), points [PTS_W-1:0] out (0 for 0 and 5..7).
module score_points_lut
   import score_pkg::*;
#(
   parameter int unsigned PTS_1 = DEF_PTS_1,
   parameter int unsigned PTS_2 = DEF_PTS_2,
   parameter int unsigned PTS_3 = DEF_PTS_3,
   parameter int unsigned PTS_4 = DEF_PTS_4,
   parameter int unsigned PTS_W = 6
) (
   input  logic [2:0]       lines,
   output logic [PTS_W-1:0] points
);

   always_comb begin
      points = '0;
      case (lines)
         3'd1:    points = PTS_W'(PTS_1);
         3'd2:    points = PTS_W'(PTS_2);
         3'd3:    points = PTS_W'(PTS_3);
         3'd4:    points = PTS_W'(PTS_4);
         // No lines or an impossible count: the event is legal but scores nothing.
         default: points = '0;
      endcase
   end

endmodule

// File: rtl/score_hit_sequencer.sv
// Merges line-clear points and soft-drop bonuses into a pending total and
// drains it as single-cycle hit pulses to the BCD score counter, stopping at 999.
// Latency: first hit the cycle after acceptance, then one hit every HIT_GAP+1 cycles.
// Backpressure: clear_ready drops when a worst-case clear could overflow pending;
//    a drop bonus that would overflow is discarded; once saturated everything is
//    accepted and thrown away.
// Ports:
//    clk, rst            clock, synchronous active-high reset
//    clear_valid/_ready  line-clear handshake, clear_lines [2:0] sampled on accept
//    drop_bonus          single-cycle +1 point request
//    score_bcd [11:0]    current counter value (3 BCD digits)
//    hit                 increment strobe to the counter
//    busy                sequencer active or points still pending
//    saturated           score reached 999, sticky until rst
//    pending [PEND_W-1:0] points not yet issued
module score_hit_sequencer
   import score_pkg::*;
#(
   parameter int unsigned PTS_1   = DEF_PTS_1,
   parameter int unsigned PTS_2   = DEF_PTS_2,
   parameter int unsigned PTS_3   = DEF_PTS_3,
   parameter int unsigned PTS_4   = DEF_PTS_4,
   parameter int unsigned PEND_W  = 6,
   parameter int unsigned HIT_GAP = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_valid,
   input  logic [2:0]        clear_lines,
   output logic              clear_ready,
   input  logic              drop_bonus,
   input  logic [11:0]       score_bcd,
   output logic              hit,
   output logic              busy,
   output logic              saturated,
   output logic [PEND_W-1:0] pending
);

   localparam int unsigned PEND_MAX = (1 << PEND_W) - 1;
   // One spare bit so pending + clear + drop can be checked before it wraps.
   localparam int unsigned SUM_W    = PEND_W + 1;

   // A clear is only taken while the largest possible award still fits with
   // room for one more drop bonus.
   localparam logic [PEND_W-1:0] READY_LIM = PEND_W'(PEND_MAX - PTS_4 - 1);
   localparam logic [SUM_W-1:0]  SUM_MAX   = SUM_W'(PEND_MAX);
   localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(HIT_GAP);

   // ------------------------------------------------------------------
   // Parameter sanity, caught at elaboration
   // ------------------------------------------------------------------
   if (PTS_4 + 1 >= PEND_MAX) begin : g_bad_pend_w
      $error("score_hit_sequencer: PTS_4 + 1 must be smaller than 2**PEND_W - 1");
   end
   if (PTS_4 < PTS_1 || PTS_4 < PTS_2 || PTS_4 < PTS_3) begin : g_bad_pts_4
      $error("score_hit_sequencer: PTS_4 must be the largest points value");
   end
   if (HIT_GAP > GAP_MAX) begin : g_bad_gap
      $error("score_hit_sequencer: HIT_GAP must be in 0..15");
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t             state;
   logic [PEND_W-1:0]  pend_q;
   logic [GAP_W-1:0]   gap_cnt;
   logic               sat_q;

   // ------------------------------------------------------------------
   // Points decode
   // ------------------------------------------------------------------
   logic [PEND_W-1:0]  lut_pts;

   score_points_lut #(
      .PTS_1 (PTS_1),
      .PTS_2 (PTS_2),
      .PTS_3 (PTS_3),
      .PTS_4 (PTS_4),
      .PTS_W (PEND_W)
   ) u_points_lut (
      .lines  (clear_lines),
      .points (lut_pts)
   );

   // ------------------------------------------------------------------
   // Accept and accumulate
   // ------------------------------------------------------------------
   logic               at_max;
   logic               discard;
   logic               clear_accept;
   logic               drop_accept;
   logic [SUM_W-1:0]   clear_add;
   logic [SUM_W-1:0]   pend_plus_clear;
   logic [SUM_W-1:0]   pend_sum;
   logic [PEND_W-1:0]  pend_nxt;

   assign at_max       = (score_bcd == BCD_MAX);
   // Once the counter is at 999 (or already latched there) every event is
   // swallowed so nothing can ever push the counter past the top.
   assign discard      = at_max || (state == SAT);

   assign clear_ready  = (pend_q <= READY_LIM) || sat_q;
   assign clear_accept = clear_valid && clear_ready;

   assign clear_add       = (clear_accept && !discard) ? {1'b0, lut_pts} : '0;
   assign pend_plus_clear = {1'b0, pend_q} + clear_add;

   // The drop bonus only lands if it leaves pending at or below its maximum.
   assign drop_accept  = drop_bonus && !discard && (pend_plus_clear < SUM_MAX);

   // hit is only ever high in ISSUE, and ISSUE is only entered or held with a
   // non-zero pending, so the subtraction cannot borrow.
   assign pend_sum = pend_plus_clear + SUM_W'(drop_accept) - SUM_W'(hit);

   always_comb begin
      pend_nxt = pend_sum[PEND_W-1:0];
      if (discard) begin
         pend_nxt = '0;
      end else if (pend_sum > SUM_MAX) begin
         // Unreachable with the accept rules above; clamps rather than wraps.
         pend_nxt = PEND_W'(PEND_MAX);
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // hit comes from the registered state and the counter's registered value,
   // so the strobe at 999 is suppressed in the very cycle the counter gets there.
   assign hit       = (state == ISSUE) && !at_max;
   assign busy      = (state != IDLE) || (pend_q != '0);
   assign saturated = sat_q;
   assign pending   = pend_q;

   // ------------------------------------------------------------------
   // Sequencer FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pend_q  <= '0;
         gap_cnt <= '0;
         sat_q   <= 1'b0;
      end else begin
         pend_q <= pend_nxt;

         if (discard) begin
            state   <= SAT;
            sat_q   <= 1'b1;
            gap_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (pend_nxt != '0) begin
                     state <= ISSUE;
                  end
               end

               ISSUE: begin
                  if (HIT_GAP > 0) begin
                     gap_cnt <= GAP_LOAD;
                     state   <= GAP;
                  end else if (pend_nxt != '0) begin
                     state <= ISSUE;
                  end else begin
                     state <= IDLE;
                  end
               end

               GAP: begin
                  // Leaves on the cycle the count reaches zero, so HIT_GAP
                  // idle cycles separate consecutive hits. A zero count can
                  // only appear through corruption; treat it as expired.
                  gap_cnt <= (gap_cnt == '0) ? '0 : gap_cnt - 1'b1;
                  if (gap_cnt <= 1) begin
                     state <= (pend_q != '0) ? ISSUE : IDLE;
                  end
               end

               default: begin
                  state <= SAT;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_score_hit_sequencer.sv
// Directed bench for score_hit_sequencer with a BCD counter model on each DUT.
// Two instances: HIT_GAP=0 (main) and HIT_GAP=2 (gap), sharing all stimulus.
// Every check is an immediate assertion; counts are reported in the summary line.
module tb_score_hit_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear_valid;
   logic [2:0]  clear_lines;
   logic        drop_bonus;

   // Counter models: score0 feeds the HIT_GAP=0 instance, scoreg the HIT_GAP=2 one.
   logic        hold;
   logic        score_ld;
   logic [11:0] score_ld_val;
   logic [11:0] score0 = 12'h000;
   logic [11:0] scoreg = 12'h000;

   logic        clear_ready0, hit0, busy0, sat0;
   logic [5:0]  pend0;
   logic        clear_readyg, hitg, busyg, satg;
   logic [5:0]  pendg;

   int n_checks = 0;
   int n_fails  = 0;
   int peak;
   int waited;

   always #5 clk = ~clk;

   score_hit_sequencer #(.HIT_GAP(0)) dut (
      .clk         (clk),
      .rst         (rst),
      .clear_valid (clear_valid),
      .clear_lines (clear_lines),
      .clear_ready (clear_ready0),
      .drop_bonus  (drop_bonus),
      .score_bcd   (score0),
      .hit         (hit0),
      .busy        (busy0),
      .saturated   (sat0),
      .pending     (pend0)
   );

   score_hit_sequencer #(.HIT_GAP(2)) dut_g (
      .clk         (clk),
      .rst         (rst),
      .clear_valid (clear_valid),
      .clear_lines (clear_lines),
      .clear_ready (clear_readyg),
      .drop_bonus  (drop_bonus),
      .score_bcd   (scoreg),
      .hit         (hitg),
      .busy        (busyg),
      .saturated   (satg),
      .pending     (pendg)
   );

   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [3:0] d0, d1, d2;
      d0 = v[3:0];
      d1 = v[7:4];
      d2 = v[11:8];
      if (d0 == 4'd9) begin
         d0 = 4'd0;
         if (d1 == 4'd9) begin
            d1 = 4'd0;
            d2 = (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
         end else begin
            d1 = d1 + 4'd1;
         end
      end else begin
         d0 = d0 + 4'd1;
      end
      return {d2, d1, d0};
   endfunction

   always @(posedge clk) begin
      if (score_ld) begin
         score0 <= score_ld_val;
         scoreg <= score_ld_val;
      end else if (!hold) begin
         if (hit0) score0 <= bcd_inc(score0);
         if (hitg) scoreg <= bcd_inc(scoreg);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      clear_valid  = 1'b0;
      clear_lines  = 3'd0;
      drop_bonus   = 1'b0;
      hold         = 1'b0;
      score_ld     = 1'b1;
      score_ld_val = 12'h000;
      tick();
      tick();

      // ---- Reset state ----
      check("rst_hit",    hit0, 0);
      check("rst_busy",   busy0, 0);
      check("rst_pend",   pend0, 0);
      check("rst_ready",  clear_ready0, 1);
      check("rst_sat",    sat0, 0);
      rst      = 1'b0;
      score_ld = 1'b0;
      repeat (10) tick();
      check("idle_hit",    hit0, 0);
      check("idle_busy",   busy0, 0);
      check("idle_pend",   pend0, 0);
      check("idle_ready",  clear_ready0, 1);
      check("idle_sat",    sat0, 0);
      check("idle_g_hit",  hitg, 0);
      check("idle_g_busy", busyg, 0);
      check("idle_g_ready", clear_readyg, 1);
      check("idle_g_sat",  satg, 0);

      // ---- 4-line clear from 000: 8 back-to-back hits ----
      clear_valid = 1'b1;
      clear_lines = 3'd4;
      check("t2_ready_c0", clear_ready0, 1);
      check("t2_hit_c0",   hit0, 0);
      tick();
      clear_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         check($sformatf("t2_hit_c%0d", k), hit0, (k <= 8) ? 1 : 0);
         if (k == 1) check("t2_pend_c1", pend0, 8);
         if (k == 8) check("t2_busy_c8", busy0, 1);
         if (k == 9) check("t2_busy_c9", busy0, 0);
         tick();
      end
      check("t2_score", score0, 12'h008);

      // ---- 2-line clear + drop, then a drop mid-drain: 5 hits ----
      clear_valid = 1'b1;
      clear_lines = 3'd2;
      drop_bonus  = 1'b1;
      tick();
      clear_valid = 1'b0;
      drop_bonus  = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         check($sformatf("t3_hit_c%0d", k), hit0, (k <= 5) ? 1 : 0);
         if (k == 1) check("t3_pend_c1", pend0, 4);
         if (k == 3) check("t3_pend_c3", pend0, 3);
         drop_bonus = (k == 2);
         tick();
      end
      check("t3_score", score0, 12'h013);
      check("t3_pend",  pend0, 0);

      // ---- Saturation from 997 ----
      score_ld     = 1'b1;
      score_ld_val = 12'h997;
      tick();
      score_ld    = 1'b0;
      clear_valid = 1'b1;
      clear_lines = 3'd4;
      tick();
      clear_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         check($sformatf("t4_hit_c%0d", k), hit0, (k <= 2) ? 1 : 0);
         tick();
      end
      check("t4_score", score0, 12'h999);
      check("t4_sat",   sat0, 1);
      check("t4_pend",  pend0, 0);
      clear_valid = 1'b1;
      drop_bonus  = 1'b1;
      check("t4_ready_sat", clear_ready0, 1);
      tick();
      clear_valid = 1'b0;
      drop_bonus  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t4_nohit_%0d", k), hit0, 0);
         check($sformatf("t4_nopend_%0d", k), pend0, 0);
         tick();
      end
      check("t4_sat_sticky", sat0, 1);
      check("t4_score_held", score0, 12'h999);

      // ---- Back-to-back 4-line clears with the counter held ----
      rst          = 1'b1;
      score_ld     = 1'b1;
      score_ld_val = 12'h000;
      tick();
      rst      = 1'b0;
      score_ld = 1'b0;
      hold     = 1'b1;
      check("t5_rst_sat", sat0, 0);
      clear_valid = 1'b1;
      clear_lines = 3'd4;
      peak = 0;
      for (int k = 0; k <= 19; k++) begin
         if (int'(pend0) > peak) peak = int'(pend0);
         if (k == 7) begin
            check("t5_pend_c7",  pend0, 50);
            check("t5_ready_c7", clear_ready0, 1);
         end
         if (k == 8) begin
            check("t5_pend_c8",  pend0, 57);
            check("t5_ready_c8", clear_ready0, 0);
         end
         if (k == 11) begin
            check("t5_pend_c11",  pend0, 54);
            check("t5_ready_c11", clear_ready0, 1);
         end
         tick();
      end
      clear_valid = 1'b0;
      check("t5_peak", peak, 61);
      check("t5_pend_c20", pend0, 61);
      repeat (7) tick();
      check("t5_drain_pend",  pend0, 54);
      check("t5_drain_ready", clear_ready0, 1);
      waited = 0;
      while (busy0 && waited < 100) begin
         tick();
         waited++;
      end
      check("t5_drain_timeout", (waited < 100) ? 1 : 0, 1);
      check("t5_drain_end", pend0, 0);
      check("t5_score_held", score0, 12'h000);

      // ---- HIT_GAP=2, 3-line clear, reset after the second hit ----
      hold         = 1'b0;
      rst          = 1'b1;
      score_ld     = 1'b1;
      score_ld_val = 12'h000;
      tick();
      rst      = 1'b0;
      score_ld = 1'b0;
      clear_valid = 1'b1;
      clear_lines = 3'd3;
      tick();
      clear_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         check($sformatf("t6_ghit_c%0d", k), hitg, (k == 1 || k == 4) ? 1 : 0);
         check($sformatf("t6_hit_c%0d", k), hit0, 1);
         if (k == 5) begin
            check("t6_gpend_c5", pendg, 3);
            rst = 1'b1;
         end
         tick();
      end
      rst = 1'b0;
      check("t6_gpend_rst", pendg, 0);
      check("t6_gbusy_rst", busyg, 0);
      check("t6_pend_rst",  pend0, 0);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("t6_ghit_after_%0d", k), hitg, 0);
         tick();
      end
      check("t6_gscore", scoreg, 12'h002);
      check("t6_score",  score0, 12'h005);
      check("t6_gbusy_end", busyg, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
